eth_crc32_calc: RTL and testbench
=================================

// Module: eth_crc32_calc
// PURPOSE
//  Byte-serial Ethernet FCS (CRC-32, IEEE 802.3) generator for the transmit frame FSM.
//  Accumulates every enabled byte after the SFD (dest addr .. payload).
//  Continuously presents the finished 32-bit FCS; the FSM appends it after the last payload byte.
// PARAMETERS
//  POLY      32'h04C11DB7  generator polynomial, normal form; implemented bit-reflected (0xEDB88320)
//  CRC_INIT  32'hFFFFFFFF  CRC register value at reset and while iafter_d5=0
// PORTS
//  ieth_clk      in   1   clock; all state on rising edge
//  ieth_rst_n    in   1   reset: asynchronous, active-low
//  iafter_d5     in   1   1 = SFD (0xD5) passed, frame body in progress; 0 = idle/reinit
//  ipayload_end  in   1   pulse: payload finished, freeze result
//  ieth_ena      in   1   1 = ieth_data is a frame byte to accumulate this cycle
//  ieth_data     in   8   frame byte, LSB is the first bit on the wire
//  ocrc32_data   out  32  FCS = ~crc_reg; [7:0] transmitted first, [31:24] last
// BEHAVIOUR
//  - State: crc_reg[31:0], done flag (1 bit).
//  - Reset (ieth_rst_n=0, async): crc_reg=CRC_INIT, done=0 -> ocrc32_data=32'h00000000.
//  - Per rising edge, priority order:
//    1) iafter_d5=0: crc_reg<=CRC_INIT, done<=0 (inputs ignored).
//    2) ipayload_end=1: done<=1, crc_reg holds; same-cycle ieth_data is NOT accumulated.
//    3) ieth_ena=1 and done=0: crc_reg<=next(crc_reg,ieth_data), reflected algorithm:
//       8 iterations, LSB first: c = (c>>1) ^ ((c[0]^d[k]) ? 32'hEDB88320 : 0).
//       Computed combinationally in one cycle (unrolled 8-bit step); one byte/clock max.
//    4) otherwise hold.
//  - ocrc32_data = ~crc_reg, combinational from register: valid one clock after last
//    accumulated byte, no extra pipeline. Stable while done=1 until iafter_d5 drops.
//  - Byte order: ocrc32_data[7:0],[15:8],[23:16],[31:24] sent in that order (FSM index 3..0
//    of a [0:3][7:0] view).
//  - ieth_ena gaps (ena=0 mid-frame) leave crc_reg unchanged; no byte counting.
//  - ipayload_end while done=1 or iafter_d5=0: no effect beyond rule 1/2.
//  - Bytes with ieth_ena=1 while done=1 are ignored until a new frame (iafter_d5 0->1).
//  - Reset mid-frame: immediate return to CRC_INIT; next frame starts clean.
//  - No X propagation: all state reset; ieth_data only sampled when rule 3 applies.
// TESTING
//  1) Assert ieth_rst_n=0 -> ocrc32_data=32'h00000000; release, iafter_d5=0 -> stays 0.
//  2) iafter_d5=1, ena bytes "123456789" (0x31..0x39), 9 clocks -> ocrc32_data=32'hCBF43926
//     ([7:0]=0x26 first).
//  3) Single byte 0x00 accepted -> ocrc32_data=32'hD202EF8D; ena gaps between bytes of
//     test 2 -> same 32'hCBF43926.
//  4) After test 2 pulse ipayload_end, then feed 0xAA with ena=1 -> value stays 32'hCBF43926.
//  5) Drop iafter_d5 for 1 clock -> 0x00000000; rerun test 2 -> 32'hCBF43926 again.
//  6) Full min frame (DA/SA/type/46-byte payload) vs software CRC-32 model; appended FCS
//     makes residue check 32'hC704DD7B on receive side.

Source files
------------

// File: rtl/eth_crc32_calc_if.sv
// eth_crc32_calc_if
//   Byte stream and FCS result between the transmit frame FSM and the CRC-32
//   calculator.
//   iafter_d5     : frame body in progress (SFD passed); 0 reinitialises the CRC
//   ipayload_end  : pulse, freezes the finished FCS
//   ieth_ena      : ieth_data carries a frame byte this cycle
//   ieth_data     : frame byte, bit 0 is first on the wire
//   ocrc32_data   : FCS, [7:0] transmitted first
//   master = frame FSM side, slave = CRC calculator side.
interface eth_crc32_calc_if;
    logic        iafter_d5;
    logic        ipayload_end;
    logic        ieth_ena;
    logic [7:0]  ieth_data;
    logic [31:0] ocrc32_data;

    modport master (
        output iafter_d5,
        output ipayload_end,
        output ieth_ena,
        output ieth_data,
        input  ocrc32_data
    );

    modport slave (
        input  iafter_d5,
        input  ipayload_end,
        input  ieth_ena,
        input  ieth_data,
        output ocrc32_data
    );
endinterface

// File: rtl/eth_crc32_calc.sv
// eth_crc32_calc
//   Byte-serial Ethernet FCS (CRC-32, IEEE 802.3) generator. Accumulates every
//   enabled frame byte after the SFD and continuously presents the finished FCS
//   for the transmit FSM to append after the last payload byte.
//   ieth_clk    : clock, all state on the rising edge
//   ieth_rst_n  : asynchronous active-low reset
//   bus         : byte stream in / FCS out (slave side of eth_crc32_calc_if)
module eth_crc32_calc #(
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic            ieth_clk,
    input  logic            ieth_rst_n,
    eth_crc32_calc_if.slave bus
);

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = {<<{v}};
        return r;
    endfunction

    // LSB-first wire order means the register runs in reflected form.
    localparam logic [31:0] POLY_REFL = reflect32(POLY);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;
    logic        done;

    // One full byte per clock: eight reflected shift/xor steps unrolled.
    always_comb begin
        crc_next = crc_reg;
        for (int unsigned k = 0; k < 8; k++) begin
            if (crc_next[0] ^ bus.ieth_data[k[2:0]])
                crc_next = (crc_next >> 1) ^ POLY_REFL;
            else
                crc_next = crc_next >> 1;
        end
    end

    always_ff @(posedge ieth_clk or negedge ieth_rst_n) begin
        if (!ieth_rst_n) begin
            crc_reg <= CRC_INIT;
            done    <= 1'b0;
        end else if (!bus.iafter_d5) begin
            crc_reg <= CRC_INIT;
            done    <= 1'b0;
        end else if (bus.ipayload_end) begin
            // Freeze; the byte presented alongside the end pulse is not part of the body.
            done    <= 1'b1;
        end else if (bus.ieth_ena && !done) begin
            crc_reg <= crc_next;
        end
    end

    assign bus.ocrc32_data = ~crc_reg;

endmodule

// File: tb/tb_eth_crc32_calc.sv
// tb_eth_crc32_calc
//   Randomised self-checking bench for eth_crc32_calc. Expected FCS values come
//   from known CRC-32 check values and from an MSB-first textbook CRC model
//   applied to bit-reversed bytes.
module tb_eth_crc32_calc;

    logic ieth_clk;
    logic ieth_rst_n;

    eth_crc32_calc_if bus ();

    eth_crc32_calc #(
        .POLY     (32'h04C11DB7),
        .CRC_INIT (32'hFFFFFFFF)
    ) dut (
        .ieth_clk   (ieth_clk),
        .ieth_rst_n (ieth_rst_n),
        .bus        (bus)
    );

    initial ieth_clk = 1'b0;
    always #5 ieth_clk = ~ieth_clk;

    int unsigned n_tests;
    int unsigned n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        r = {<<{v}};
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        r = {<<{v}};
        return r;
    endfunction

    // Normal-form MSB-first CRC-32 with reflected input/output.
    function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {rev8(q[i]), 24'h000000};
            for (int b = 0; b < 8; b++)
                r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return ~rev32(r);
    endfunction

    task automatic tick();
        @(posedge ieth_clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        bus.ieth_ena  = 1'b1;
        bus.ieth_data = b;
        tick();
        bus.ieth_ena  = 1'b0;
        bus.ieth_data = 8'($urandom);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ieth_ena  = 1'b0;
            bus.ieth_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic new_frame();
        bus.iafter_d5    = 1'b0;
        bus.ipayload_end = 1'b0;
        tick();
        bus.iafter_d5    = 1'b1;
    endtask

    task automatic feed_digits(input bit with_gaps);
        for (int i = 0; i < 9; i++) begin
            feed(8'h31 + 8'(i));
            if (with_gaps) gap(i % 3);
        end
    endtask

    task automatic end_pulse(input logic [7:0] stray);
        bus.ipayload_end = 1'b1;
        bus.ieth_ena     = 1'b1;
        bus.ieth_data    = stray;
        tick();
        bus.ipayload_end = 1'b0;
        bus.ieth_ena     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  frame[$];
        logic [31:0] exp;
        logic [31:0] res;
        int          len;

        n_tests = 0;
        n_fail  = 0;
        ieth_rst_n       = 1'b0;
        bus.iafter_d5    = 1'b0;
        bus.ipayload_end = 1'b0;
        bus.ieth_ena     = 1'b0;
        bus.ieth_data    = 8'h00;

        repeat (3) tick();
        check_eq("reset", bus.ocrc32_data, 32'h00000000);
        ieth_rst_n = 1'b1;
        bus.ieth_ena = 1'b1;
        bus.ieth_data = 8'h5A;
        repeat (3) tick();
        bus.ieth_ena = 1'b0;
        check_eq("idle_after_reset", bus.ocrc32_data, 32'h00000000);

        new_frame();
        feed_digits(1'b0);
        check_eq("check_123456789", bus.ocrc32_data, 32'hCBF43926);
        check_eq("first_byte_out", {24'h0, bus.ocrc32_data[7:0]}, 32'h00000026);

        end_pulse(8'hAA);
        check_eq("end_pulse_no_accum", bus.ocrc32_data, 32'hCBF43926);
        feed(8'hAA);
        feed(8'hAA);
        end_pulse(8'h55);
        check_eq("frozen_after_end", bus.ocrc32_data, 32'hCBF43926);

        bus.iafter_d5 = 1'b0;
        bus.ipayload_end = 1'b1;
        bus.ieth_ena = 1'b1;
        bus.ieth_data = 8'h31;
        tick();
        bus.ipayload_end = 1'b0;
        bus.ieth_ena = 1'b0;
        check_eq("d5_drop_reinit", bus.ocrc32_data, 32'h00000000);
        bus.iafter_d5 = 1'b1;
        feed_digits(1'b0);
        check_eq("rerun_123456789", bus.ocrc32_data, 32'hCBF43926);

        new_frame();
        feed(8'h00);
        check_eq("single_zero", bus.ocrc32_data, 32'hD202EF8D);

        new_frame();
        feed_digits(1'b1);
        check_eq("gapped_123456789", bus.ocrc32_data, 32'hCBF43926);

        // Minimum frame: DA, SA, type, 46-byte payload.
        frame.delete();
        for (int i = 0; i < 6; i++)  frame.push_back(8'hFF);
        for (int i = 0; i < 6; i++)  frame.push_back(8'h02 + 8'(i));
        frame.push_back(8'h08);
        frame.push_back(8'h00);
        for (int i = 0; i < 46; i++) frame.push_back(8'($urandom));
        exp = crc_model(frame);
        new_frame();
        foreach (frame[i]) feed(frame[i]);
        end_pulse(8'($urandom));
        check_eq("min_frame_fcs", bus.ocrc32_data, exp);

        new_frame();
        foreach (frame[i]) feed(frame[i]);
        feed(exp[7:0]);
        feed(exp[15:8]);
        feed(exp[23:16]);
        feed(exp[31:24]);
        res = ~bus.ocrc32_data;
        check_eq("residue", rev32(res), 32'hC704DD7B);

        for (int f = 0; f < 20; f++) begin
            frame.delete();
            len = $urandom_range(1, 64);
            new_frame();
            for (int i = 0; i < len; i++) begin
                frame.push_back(8'($urandom));
                feed(frame[i]);
                gap($urandom_range(0, 2));
            end
            end_pulse(8'($urandom));
            feed(8'($urandom));
            check_eq($sformatf("rand_frame_%0d", f), bus.ocrc32_data, crc_model(frame));
        end

        new_frame();
        feed(8'h12);
        feed(8'h34);
        feed(8'h56);
        #2;
        ieth_rst_n = 1'b0;
        #1;
        check_eq("async_reset_mid_frame", bus.ocrc32_data, 32'h00000000);
        tick();
        ieth_rst_n = 1'b1;
        feed_digits(1'b0);
        check_eq("after_reset_clean", bus.ocrc32_data, 32'hCBF43926);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
